// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready request and result handshake.
// Single-cycle ops (ADD..SRA and pass-through codes) finish one cycle after
// acceptance. MUL/DIVU/REMU are iterative and exist only when the macro
// ALU_MC_MULDIV_EN is defined. Without it, codes 10-12 behave as pass-through.
module alu_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [CTRL_WIDTH-1:0] ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  eq,
    output logic                  busy
);

    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [CTRL_WIDTH-1:0] OP_ADD  = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] OP_SUB  = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] OP_AND  = CTRL_WIDTH'(2);
    localparam logic [CTRL_WIDTH-1:0] OP_OR   = CTRL_WIDTH'(3);
    localparam logic [CTRL_WIDTH-1:0] OP_XOR  = CTRL_WIDTH'(4);
    localparam logic [CTRL_WIDTH-1:0] OP_SLT  = CTRL_WIDTH'(5);
    localparam logic [CTRL_WIDTH-1:0] OP_SLTU = CTRL_WIDTH'(6);
    localparam logic [CTRL_WIDTH-1:0] OP_SLL  = CTRL_WIDTH'(7);
    localparam logic [CTRL_WIDTH-1:0] OP_SRL  = CTRL_WIDTH'(8);
    localparam logic [CTRL_WIDTH-1:0] OP_SRA  = CTRL_WIDTH'(9);

`ifdef ALU_MC_MULDIV_EN
    localparam logic [CTRL_WIDTH-1:0] OP_MUL  = CTRL_WIDTH'(10);
    localparam logic [CTRL_WIDTH-1:0] OP_DIVU = CTRL_WIDTH'(11);
    localparam logic [CTRL_WIDTH-1:0] OP_REMU = CTRL_WIDTH'(12);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

    state_t                r_state;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_eq;

    logic [SHW-1:0]        w_shamt;
    logic                  w_slt;
    logic                  w_sltu;
    logic [DATA_WIDTH-1:0] w_quick;

`ifdef ALU_MC_MULDIV_EN
    // r_a: multiplicand (MUL) or dividend/quotient shift register (DIV/REM)
    // r_b: multiplier (MUL) or divisor (DIV/REM)
    // r_rem: product accumulator (MUL) or partial remainder (DIV/REM)
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [CTRL_WIDTH-1:0] r_op;
    logic                  r_eq_hold;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_is_iter;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_sub;
    logic                  w_ge;

    assign w_is_iter = (ctrl == OP_MUL) || (ctrl == OP_DIVU) || (ctrl == OP_REMU);
    // One restoring-divide step: shift in the next dividend bit, try to subtract.
    assign w_shift   = {r_rem, r_a[DATA_WIDTH-1]};
    assign w_sub     = w_shift - {1'b0, r_b};
    assign w_ge      = ~w_sub[DATA_WIDTH];
`endif

    assign in_ready  = rst_n && (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign eq        = r_eq;

    assign w_shamt = op_b[SHW-1:0];
    assign w_slt   = $signed(op_a) < $signed(op_b);
    assign w_sltu  = op_a < op_b;

    // Single-cycle result computed straight from the request operands.
    always_comb begin
        w_quick = op_a;
        case (ctrl)
            OP_ADD:  w_quick = op_a + op_b;
            OP_SUB:  w_quick = op_a - op_b;
            OP_AND:  w_quick = op_a & op_b;
            OP_OR:   w_quick = op_a | op_b;
            OP_XOR:  w_quick = op_a ^ op_b;
            OP_SLT:  w_quick = {{(DATA_WIDTH-1){1'b0}}, w_slt};
            OP_SLTU: w_quick = {{(DATA_WIDTH-1){1'b0}}, w_sltu};
            OP_SLL:  w_quick = op_a << w_shamt;
            OP_SRL:  w_quick = op_a >> w_shamt;
            OP_SRA:  w_quick = $unsigned($signed(op_a) >>> w_shamt);
            default: w_quick = op_a;
        endcase
    end

    // Control FSM with registered outputs and the iterative mul/div datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_eq        <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
`ifdef ALU_MC_MULDIV_EN
                        if (w_is_iter) begin
                            r_state   <= S_CALC;
                            r_a       <= op_a;
                            r_b       <= op_b;
                            r_op      <= ctrl;
                            r_rem     <= '0;
                            r_cnt     <= '0;
                            r_eq_hold <= (op_a == op_b);
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_quick;
                            r_eq        <= (op_a == op_b);
                        end
`else
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_quick;
                        r_eq        <= (op_a == op_b);
`endif
                    end
                end
`ifdef ALU_MC_MULDIV_EN
                S_CALC: begin
                    if (r_cnt == CNT_W'(DATA_WIDTH)) begin
                        // All bits processed: publish the result.
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_eq        <= r_eq_hold;
                        r_result    <= (r_op == OP_DIVU) ? r_a : r_rem;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_op == OP_MUL) begin
                            if (r_b[0]) begin
                                r_rem <= r_rem + r_a;
                            end
                            r_a <= r_a << 1;
                            r_b <= r_b >> 1;
                        end else begin
                            // Divide by zero naturally yields all-ones / op_a.
                            r_a   <= {r_a[DATA_WIDTH-2:0], w_ge};
                            r_rem <= w_ge ? w_sub[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
                        end
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
